regfile_write_arbiter: RTL
==========================

Name: regfile_write_arbiter

Overview:
- Shares the register file's single write port between two writeback requesters: ALU result (port A) and memory load (port M).
- Round-robin arbitration with a valid/ready handshake.
- Partial-width writes (byte or halfword into the low bits, upper bits preserved) are sequenced as a 2-cycle read-modify-write using a dedicated register-file read port.
- Sits between the execute/memory stages and the register file. Replaces direct RegWrite/RegDst steering.

Parameters:
- DATA_W, 32, register width in bits.
- ADDR_W, 5, register index width.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- a_valid  input  1  ALU write request.
- a_ready  output  1  ALU request accepted this cycle.
- a_addr  input  ADDR_W  ALU destination register.
- a_data  input  DATA_W  ALU write data.
- a_size  input  2  00 word, 01 byte, 10 halfword, 11 treated as word.
- m_valid, m_ready, m_addr, m_data, m_size  same as the a_* ports, for the memory requester.
- rf_rd_addr  output  ADDR_W  register-file merge-read address (registered).
- rf_rd_data  input  DATA_W  register-file combinational read data for rf_rd_addr.
- rf_wr_en  output  1  register-file write enable (registered).
- rf_wr_addr  output  ADDR_W  write address (registered).
- rf_wr_data  output  DATA_W  write data (registered).
- busy  output  1  high while in the RMW state.

Behaviour:
- Reset (async, rst_n=0):
  - State = IDLE.
  - rf_wr_en=0, rf_wr_addr=0, rf_wr_data=0, rf_rd_addr=0, busy=0.
  - Last-served pointer = M, so A wins the first tie.
  - a_ready and m_ready are low while in reset.
- Handshake:
  - A transfer occurs when valid && ready at a rising edge.
  - Ready is combinational from state, pointer and valids.
  - Requesters hold addr/data/size stable while valid is high and ready is low.
- Arbitration (state IDLE only):
  - Only one valid: that requester gets ready=1.
  - Both valid: the requester that was not last served gets ready=1, and the other gets 0.
  - The pointer updates on every transfer.
  - In RMW, both readies are 0.
- Full-word transfer (size 00/11):
  - At the accepting edge: rf_wr_en<=1, rf_wr_addr<=addr, rf_wr_data<=data.
  - State stays IDLE, so back-to-back writes are possible at one per cycle.
  - The register file commits on the following edge.
- Partial transfer (size 01/10):
  - At the accepting edge: rf_rd_addr<=addr, the request (addr, low data, size) is latched, rf_wr_en<=0, and state goes to RMW.
  - In RMW: merged = {rf_rd_data[DATA_W-1:8], data[7:0]} for byte, or {rf_rd_data[DATA_W-1:16], data[15:0]} for halfword.
  - At the next edge: rf_wr_en<=1, rf_wr_addr<=latched addr, rf_wr_data<=merged, and state goes to IDLE.
  - Latency is 2 cycles from acceptance to rf_wr_en.
- rf_wr_en deasserts at the next edge unless a new write is launched at that edge. It is a one-cycle pulse per write.
- Register 0:
  - Requests with addr==0 are accepted normally but produce no write (rf_wr_en stays 0).
  - Partial requests to r0 still take 2 cycles.
- Ordering (write then merge-read to the same register):
  - Writes are issued strictly in acceptance order.
  - A full write accepted at cycle t commits at edge t+2. A partial accepted at t+1 reads in RMW during cycle t+2, which is after that commit, so no forwarding is needed.
  - The register file must therefore write on the rising edge when rf_wr_en=1.
- Reset mid-RMW: the pending partial write is discarded, with no write issued after reset.
- No request is ever dropped. A losing requester waits at most one grant.

Test Plan:
- Single ALU word write: a_valid=1, a_addr=5, a_data=32'hDEADBEEF → a_ready=1 same cycle; next cycle rf_wr_en=1, rf_wr_addr=5, rf_wr_data=DEADBEEF; the following cycle rf_wr_en=0.
- Simultaneous requests after reset: A (r1, 11111111) and M (r2, 22222222) valid together → A served first, then M; two consecutive rf_wr_en pulses to r1 then r2.
- Byte merge: rf_rd_data(r7)=AABBCCDD, M byte write of data=000000EE → m_ready once; busy=1 for one cycle; rf_wr_data=AABBCCEE to r7, 2 cycles after acceptance; A stalled (a_ready=0) during RMW.
- Halfword merge back-to-back with a full write: A word 12345678→r3, then M half 0000BEEF→r3 → second write data=1234BEEF.
- r0 suppression: A word write to r0 → a_ready=1, rf_wr_en stays 0.
- Reset asserted during RMW → all outputs 0 immediately; after release, no write appears, and the pointer favours A.

Source files
------------

// File: rtl/regfile_write_arbiter.sv
// ============================================================================
//  regfile_write_arbiter : round-robin share of the register-file write port
//  between ALU (A) and memory (M) writeback, with byte/halfword RMW merging.
//  Revision 1.0
// ============================================================================
`default_nettype none

module regfile_write_arbiter #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              a_valid,
   output logic              a_ready,
   input  logic [ADDR_W-1:0] a_addr,
   input  logic [DATA_W-1:0] a_data,
   input  logic [1:0]        a_size,
   input  logic              m_valid,
   output logic              m_ready,
   input  logic [ADDR_W-1:0] m_addr,
   input  logic [DATA_W-1:0] m_data,
   input  logic [1:0]        m_size,
   output logic [ADDR_W-1:0] rf_rd_addr,
   input  logic [DATA_W-1:0] rf_rd_data,
   output logic              rf_wr_en,
   output logic [ADDR_W-1:0] rf_wr_addr,
   output logic [DATA_W-1:0] rf_wr_data,
   output logic              busy
);

   localparam logic [1:0] SIZE_BYTE = 2'b01;
   localparam logic [1:0] SIZE_HALF = 2'b10;
   localparam logic [DATA_W-1:0] BYTE_MASK = DATA_W'(8'hFF);
   localparam logic [DATA_W-1:0] HALF_MASK = DATA_W'(16'hFFFF);

   typedef enum logic [0:0] {
      S_IDLE = 1'b0,
      S_RMW  = 1'b1
   } state_t;

   state_t            state_q, state_d;
   logic              last_m_q, last_m_d;
   logic [ADDR_W-1:0] lat_addr_q, lat_addr_d;
   logic [DATA_W-1:0] lat_data_q, lat_data_d;
   logic              lat_half_q, lat_half_d;
   logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
   logic              wr_en_q, wr_en_d;
   logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
   logic [DATA_W-1:0] wr_data_q, wr_data_d;

   logic              idle;
   logic              xfer_a, xfer_m;
   logic [ADDR_W-1:0] sel_addr;
   logic [DATA_W-1:0] sel_data;
   logic [1:0]        sel_size;
   logic              sel_partial;
   logic [DATA_W-1:0] merge_mask;
   logic [DATA_W-1:0] merged;

   // Readies are gated by rst_n so neither requester sees a grant while reset is held.
   assign idle    = (state_q == S_IDLE);
   assign a_ready = rst_n & idle & a_valid & (~m_valid | last_m_q);
   assign m_ready = rst_n & idle & m_valid & (~a_valid | ~last_m_q);

   assign xfer_a = a_valid & a_ready;
   assign xfer_m = m_valid & m_ready;

   assign sel_addr    = xfer_a ? a_addr : m_addr;
   assign sel_data    = xfer_a ? a_data : m_data;
   assign sel_size    = xfer_a ? a_size : m_size;
   assign sel_partial = (sel_size == SIZE_BYTE) || (sel_size == SIZE_HALF);

   assign merge_mask = lat_half_q ? HALF_MASK : BYTE_MASK;
   assign merged     = (rf_rd_data & ~merge_mask) | (lat_data_q & merge_mask);

   always_comb begin
      state_d    = state_q;
      last_m_d   = last_m_q;
      lat_addr_d = lat_addr_q;
      lat_data_d = lat_data_q;
      lat_half_d = lat_half_q;
      rd_addr_d  = rd_addr_q;
      wr_en_d    = 1'b0;
      wr_addr_d  = wr_addr_q;
      wr_data_d  = wr_data_q;

      case (state_q)
         S_IDLE: begin
            if (xfer_a || xfer_m) begin
               last_m_d = xfer_m;
               if (sel_partial) begin
                  rd_addr_d  = sel_addr;
                  lat_addr_d = sel_addr;
                  lat_data_d = sel_data;
                  lat_half_d = (sel_size == SIZE_HALF);
                  state_d    = S_RMW;
               end else if (sel_addr != '0) begin
                  wr_en_d   = 1'b1;
                  wr_addr_d = sel_addr;
                  wr_data_d = sel_data;
               end
            end
         end
         S_RMW: begin
            // rf_rd_data already reflects any write issued just before acceptance.
            state_d = S_IDLE;
            if (lat_addr_q != '0) begin
               wr_en_d   = 1'b1;
               wr_addr_d = lat_addr_q;
               wr_data_d = merged;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         last_m_q   <= 1'b1;
         lat_addr_q <= '0;
         lat_data_q <= '0;
         lat_half_q <= 1'b0;
         rd_addr_q  <= '0;
         wr_en_q    <= 1'b0;
         wr_addr_q  <= '0;
         wr_data_q  <= '0;
      end else begin
         state_q    <= state_d;
         last_m_q   <= last_m_d;
         lat_addr_q <= lat_addr_d;
         lat_data_q <= lat_data_d;
         lat_half_q <= lat_half_d;
         rd_addr_q  <= rd_addr_d;
         wr_en_q    <= wr_en_d;
         wr_addr_q  <= wr_addr_d;
         wr_data_q  <= wr_data_d;
      end
   end

   assign rf_rd_addr = rd_addr_q;
   assign rf_wr_en   = wr_en_q;
   assign rf_wr_addr = wr_addr_q;
   assign rf_wr_data = wr_data_q;
   assign busy       = (state_q == S_RMW);

endmodule

`default_nettype wire
